// File: rtl/record_fifo_pkg.sv
// Shared width helpers for the word-to-record FIFO.
// Widths are derived from the module parameters, so nothing here fixes a size.
package record_fifo_pkg;

   function automatic int unsigned ptr_width(input int unsigned depth,
                                             input int unsigned rec_words);
      return $clog2(depth * rec_words) + 1;
   endfunction

   function automatic int unsigned rec_count_width(input int unsigned depth);
      return $clog2(depth) + 2;
   endfunction

   function automatic int unsigned rec_width(input int unsigned word_size,
                                             input int unsigned rec_words);
      return word_size * rec_words;
   endfunction

endpackage

// File: rtl/record_fifo_storage.sv
// Word-wide write port, whole-record combinational read at a record-aligned index.
module record_fifo_storage
   import record_fifo_pkg::*;
#(
   parameter int unsigned WordSize    = 8,
   parameter int unsigned RecordWords = 16,
   parameter int unsigned Depth       = 8
) (
   input  logic                                           clk,
   input  logic                                           wr_en,
   input  logic [$clog2(Depth*RecordWords)-1:0]           wr_idx,
   input  logic [WordSize-1:0]                            wr_data,
   input  logic [$clog2(Depth)-1:0]                       rd_rec,
   output logic [rec_width(WordSize, RecordWords)-1:0]    rd_data
);

   localparam int unsigned Words = Depth * RecordWords;
   localparam int unsigned IdxW  = $clog2(Words);
   localparam int unsigned RwLog = $clog2(RecordWords);

   logic [WordSize-1:0] mem_q [Words];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_idx] <= wr_data;
      end
   end

   // Word 0 of the record lands in the least significant slice.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < RecordWords; i++) begin
         logic [IdxW-1:0] idx;
         idx = {rd_rec, RwLog'(i)};
         rd_data[i*WordSize +: WordSize] = mem_q[idx];
      end
   end

endmodule

// File: rtl/record_fifo.sv
// Packs RecordWords input words into records and presents them through a
// registered valid/ready output stage, with flush, watermark and overflow flags.
module record_fifo
   import record_fifo_pkg::*;
#(
   parameter int unsigned WordSize        = 8,
   parameter int unsigned RecordWords     = 16,
   parameter int unsigned Depth           = 8,
   parameter int unsigned AlmostFullSlack = 1
) (
   input  logic                                        clk,
   input  logic                                        reset,
   input  logic                                        flush,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [WordSize-1:0]                         in_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [rec_width(WordSize, RecordWords)-1:0] out_data,
   output logic [ptr_width(Depth, RecordWords)-1:0]    word_count,
   output logic [rec_count_width(Depth)-1:0]           record_count,
   output logic                                        almost_full,
   output logic                                        overflow
);

   localparam int unsigned Words   = Depth * RecordWords;
   localparam int unsigned PtrW    = ptr_width(Depth, RecordWords);
   localparam int unsigned IdxW    = PtrW - 1;
   localparam int unsigned RwLog   = $clog2(RecordWords);
   localparam int unsigned RcW     = rec_count_width(Depth);
   localparam int unsigned RecW    = rec_width(WordSize, RecordWords);
   localparam int unsigned AfLimit = (Depth - AlmostFullSlack) * RecordWords;

   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic            out_valid_q;
   logic            overflow_q;
   logic [RecW-1:0] out_data_q;
   logic [RecW-1:0] rd_data;
   logic            wr_en;
   logic            load;

   assign word_count   = wr_ptr_q - rd_ptr_q;
   assign in_ready     = (word_count != PtrW'(Words));
   assign wr_en        = in_valid && in_ready && !flush;
   // Output stage refills whenever it is empty or being drained this cycle.
   assign load         = (word_count >= PtrW'(RecordWords)) && (!out_valid_q || out_ready)
                         && !flush;
   assign almost_full  = (word_count > PtrW'(AfLimit));
   assign record_count = RcW'(word_count >> RwLog) + RcW'(out_valid_q);
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign overflow     = overflow_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (load) begin
            rd_ptr_q    <= rd_ptr_q + PtrW'(RecordWords);
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (in_valid && !in_ready) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Payload needs no reset: it is only meaningful while out_valid is high.
   always_ff @(posedge clk) begin
      if (load) begin
         out_data_q <= rd_data;
      end
   end

   record_fifo_storage #(
      .WordSize    (WordSize),
      .RecordWords (RecordWords),
      .Depth       (Depth)
   ) u_storage (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_idx  (wr_ptr_q[IdxW-1:0]),
      .wr_data (in_data),
      .rd_rec  (rd_ptr_q[IdxW-1:RwLog]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_record_fifo.sv
// Directed bench for record_fifo with default parameters (8-bit words, 16-word records, 8 deep).
module tb_record_fifo;

   logic         clk = 1'b0;
   logic         reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic         almost_full, overflow;
   logic [7:0]   in_data;
   logic [127:0] out_data;
   logic [7:0]   word_count;
   logic [4:0]   record_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   record_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .word_count   (word_count),
      .record_count (record_count),
      .almost_full  (almost_full),
      .overflow     (overflow)
   );

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   function automatic logic [127:0] rec(input logic [7:0] base);
      logic [127:0] r;
      for (int j = 0; j < 16; j++) r[j*8 +: 8] = base + 8'(j);
      return r;
   endfunction

   initial begin
      int rx;
      int last_t;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      step(); step();
      reset = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_word_count", word_count, 0);
      check("rst_record_count", record_count, 0);
      check("rst_almost_full", almost_full, 0);
      check("rst_overflow", overflow, 0);

      // First record and its latency
      for (int i = 0; i < 16; i++) push(8'(i));
      check("e_out_valid", out_valid, 0);
      check("e_word_count", word_count, 16);
      step();
      check("e1_out_valid", out_valid, 1);
      check("e1_out_data", out_data, 128'h0F0E0D0C0B0A09080706050403020100);
      check("e1_record_count", record_count, 1);
      check("e1_word_count", word_count, 0);

      // Fill storage behind a full output register
      for (int k = 0; k < 128; k++) begin
         push(8'(16 + k));
         if (k == 111) begin
            check("af_at_112", almost_full, 0);
            check("wc_at_112", word_count, 112);
         end
         if (k == 112) check("af_at_113", almost_full, 1);
      end
      check("full_in_ready", in_ready, 0);
      check("full_word_count", word_count, 128);
      check("full_record_count", record_count, 9);
      check("full_overflow_pre", overflow, 0);
      push(8'hEE);
      check("ovf_set", overflow, 1);
      check("ovf_word_count", word_count, 128);
      step();
      check("ovf_sticky", overflow, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("drain1_data", out_data, rec(8'h10));
      check("drain1_word_count", word_count, 112);
      check("drain1_in_ready", in_ready, 1);
      check("drain1_overflow", overflow, 1);

      // Flush clears everything including the sticky flag
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl1_overflow", overflow, 0);
      check("fl1_word_count", word_count, 0);
      check("fl1_out_valid", out_valid, 0);
      check("fl1_record_count", record_count, 0);
      for (int i = 0; i < 40; i++) push(8'(8'h30 + i));
      check("pre_fl_out_valid", out_valid, 1);
      check("pre_fl_word_count", word_count, 24);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("fl2_word_count", word_count, 0);
      check("fl2_out_valid", out_valid, 0);
      check("fl2_overflow", overflow, 0);
      for (int i = 0; i < 16; i++) push(8'(8'hA0 + i));
      step();
      check("post_fl_out_valid", out_valid, 1);
      check("post_fl_data", out_data, rec(8'hA0));
      check("post_fl_word_count", word_count, 0);

      // Load and write in the same cycle at word_count = 16
      for (int i = 0; i < 16; i++) push(8'(8'hB0 + i));
      check("sim_pre_wc", word_count, 16);
      check("sim_pre_hold", out_data, rec(8'hA0));
      in_valid = 1'b1; in_data = 8'hC0; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("sim_wc", word_count, 1);
      check("sim_data", out_data, rec(8'hB0));
      check("sim_out_valid", out_valid, 1);
      check("sim_record_count", record_count, 1);
      step();
      check("sim_drain_valid", out_valid, 0);
      check("sim_drain_rc", record_count, 0);
      check("sim_drain_wc", word_count, 1);
      out_ready = 1'b0;
      for (int i = 1; i < 16; i++) push(8'(8'hC0 + i));
      step();
      check("sim_next_data", out_data, rec(8'hC0));
      check("sim_next_wc", word_count, 0);

      // Reset in the middle of a record
      for (int i = 0; i < 7; i++) push(8'(8'h55 + i));
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst_wc", word_count, 0);
      check("midrst_out_valid", out_valid, 0);
      for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
      step();
      check("midrst_data", out_data, rec(8'h60));
      check("midrst_record_count", record_count, 1);

      // Streaming across several pointer wraps
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      rx = 0;
      last_t = -1;
      for (int cyc = 0; cyc < 640; cyc++) begin
         if (cyc < 600) begin
            in_valid = 1'b1;
            in_data  = 8'(cyc);
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (out_valid) begin
            check("stream_data", out_data, rec(8'(rx * 16)));
            if (rx == 0) check("stream_first_t", cyc, 16);
            else check("stream_gap", cyc - last_t, 16);
            last_t = cyc;
            rx++;
         end
      end
      in_valid = 1'b0;
      check("stream_records", rx, 37);
      check("stream_leftover", word_count, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/record_fifo.md
Name: record_fifo

Overview:
Second-generation word-to-record FIFO. It accepts one WordSize word per cycle over a valid/ready handshake and packs RecordWords consecutive words into one record. Complete records are presented through a registered, valid/ready output stage. Adds reset, flush, an almost-full watermark, a sticky overflow flag and occupancy counters. It sits between the byte-stream receiver and the record (motion-segment) consumer.

Parameters:
WordSize, 8, bits per input word
RecordWords, 16, words per record; power of 2, >= 2
Depth, 8, records held in storage (excluding output register); power of 2, >= 2
AlmostFullSlack, 1, almost_full asserts when free storage space is below AlmostFullSlack records; 1 <= AlmostFullSlack <= Depth

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  synchronous discard of all content, including any partial record
in_valid  in  1  in_data is valid
in_ready  out  1  block can accept a word this cycle
in_data  in  WordSize  input word
out_valid  out  1  out_data holds a complete record
out_ready  in  1  consumer takes the record this cycle
out_data  out  WordSize*RecordWords  record; word 0 (first received) in bits [WordSize-1:0]
word_count  out  clog2(Depth*RecordWords)+1  words in storage (excludes output register)
record_count  out  clog2(Depth)+2  complete records in storage plus output register
almost_full  out  1  storage free space below AlmostFullSlack records
overflow  out  1  sticky: a word was offered while in_ready was low

Behaviour:
- Reset (and flush): write/read pointers=0, out_valid=0, overflow=0, word_count=0, record_count=0, almost_full=0, in_ready=1. out_data is don't-care while out_valid=0.
- flush has priority over in/out handshakes in the same cycle. A word offered during flush is discarded. A record presented during flush is dropped, even if out_ready=1.
- Storage: Depth*RecordWords words. Pointers are one bit wider than the index; word_count = wr_ptr - rd_ptr.
- in_ready = (word_count != Depth*RecordWords). A write occurs on in_valid && in_ready: store at wr_ptr index, wr_ptr+1. Wrap is natural modulo.
- rd_ptr always advances by exactly RecordWords. It is always a multiple of RecordWords, so a record never straddles the wrap boundary.
- Output register load condition: word_count >= RecordWords && (!out_valid || out_ready). On load, out_data <= storage[rd_idx .. rd_idx+RecordWords-1], out_valid<=1, rd_ptr += RecordWords.
- When out_valid && out_ready and no load is possible, out_valid<=0 next edge.
- Latency: the word completing a record is accepted at edge E; out_valid is high after edge E+1 (the output register was empty).
- Throughput: back-to-back records with out_ready held high and enough data → one record per cycle.
- Simultaneous write and load in one cycle: word_count updates to word_count + 1 - RecordWords. in_ready is computed from the pre-edge count; there is no combinational in_ready-from-out_ready path.
- record_count = (word_count >> log2(RecordWords)) + out_valid. A partial record is never counted.
- almost_full = word_count > (Depth - AlmostFullSlack)*RecordWords. Registered-free: combinational from pointers.
- overflow <= 1 on in_valid && !in_ready. Cleared only by reset or flush.
- Reset mid-record: partial words are lost; the first word after reset is word 0 of a new record.
- Capacity: Depth records in storage + 1 in the output register. in_ready stays high while the output register is full, as long as storage has space.

Decomposition:
- Package record_fifo_pkg: functions for pointer width, count width and record width from the parameters; no typedefs with fixed widths.
- Sub-module record_fifo_storage: word-wide write port, RecordWords-wide combinational read at a record-aligned index.
- Top holds pointers, output register, flags and handshake logic.

Test Plan:
- Reset, then feed 16 words 0x00..0x0F with out_ready=0 → out_valid rises at edge E+1; out_data=0x0F0E..0100; record_count=1; word_count=0.
- Fill with out_ready=0 and defaults → in_ready drops after 144 words (128 storage + 16 output); almost_full high once word_count>112; a further in_valid sets overflow=1, and it stays high.
- out_ready=1 and in_valid=1 continuously with incrementing words → after start-up, out_valid rises every 16 cycles; data is in-order across pointer wrap (run ≥3 wraps, scoreboard match).
- 40 words in, flush for one cycle with in_valid=1 and out_valid=1 → next cycle word_count=0, out_valid=0, overflow=0; the next 16 words form one exact record.
- Load and write in the same cycle at word_count=16 → word_count becomes 1, record_count stays correct, no word lost or duplicated.
- reset asserted after 7 words of a record → afterward word_count=0; the next 16 words alone form record 0.
